csr_supervisor_unit: RTL and testbench
======================================

Name: csr_supervisor_unit

Overview:
Parametrised S-mode CSR file, the next generation of the supervisor CSR block. It adds the following over the previous generation:
- CSRRW/CSRRS/CSRRC operation semantics.
- Address-encoded privilege and read-only checks.
- WARL write masks.
- Hardware trap entry and SRET sequencing with a registered PC redirect.
- Interrupt-pending generation.
It sits beside the M-mode CSR file and is driven by the execute stage and the trap controller.

Parameters:
XLEN, 64, CSR/data width (32 or 64)
CAUSE_W, 6, width of trap cause code (< XLEN)
VEC_EN_DEFAULT, 0, reset value of stvec.MODE (0 direct, 1 vectored)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
priv_lvl  in  2  current privilege (0=U, 1=S, 3=M)
csr_valid  in  1  CSR instruction this cycle
csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  rs1/immediate operand
csr_rdata  out  XLEN  old CSR value (combinational)
csr_illegal  out  1  access illegal (combinational; suppresses write)
trap_valid  in  1  take trap into S-mode this cycle
trap_is_irq  in  1  trap is an interrupt
trap_cause  in  CAUSE_W  exception/interrupt code
trap_pc  in  XLEN  PC of faulting instruction
trap_tval  in  XLEN  trap value
sret_valid  in  1  SRET retiring
ext_seip  in  1  external interrupt line
ext_stip  in  1  timer interrupt line
redirect_valid  out  1  registered 1-cycle redirect pulse
redirect_pc  out  XLEN  registered redirect target
new_priv  out  2  registered privilege to adopt on redirect
irq_pending  out  1  enabled S-interrupt pending (registered)
satp_out  out  XLEN  current satp value (to MMU)

Behaviour:
- Implemented CSRs: sstatus 0x100, sie 0x104, stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142, stval 0x143, sip 0x144, satp 0x180.
- csr_illegal=1 when csr_valid and any of the following holds:
  - priv_lvl < csr_addr[9:8].
  - Address not implemented.
  - csr_addr[11:10]==2'b11 and csr_op is not a no-op write. RS/RC with csr_wdata==0 counts as no write; RW always writes.
- When illegal: csr_rdata=0 and no state change.
- New value = RW: wdata; RS: old|wdata; RC: old&~wdata. It is committed at posedge, then masked per register.
- WARL masks:
  - sstatus: only SIE[1], SPIE[5], SPP[8] writable; others read 0.
  - sie: bits 1, 5, 9 writable.
  - sip: only SSIP[1] writable. STIP[5] and SEIP[9] read ext_stip and ext_seip live.
  - stvec: MODE[1:0] accepts 0/1, value 2/3 keeps old MODE; BASE[XLEN-1:2] always written.
  - sepc: bit 0 forced 0.
  - scause/stval/sscratch: full width.
- Reset: every register 0 except stvec.MODE=VEC_EN_DEFAULT. redirect_valid=0, redirect_pc=0, new_priv=0, irq_pending=0.
- Trap entry, when trap_valid:
  - sepc<=trap_pc&~1 and stval<=trap_tval.
  - scause<={trap_is_irq, zero-fill, trap_cause}, with MSB = interrupt flag.
  - SPIE<=SIE, SIE<=0, SPP<=priv_lvl[0].
  - Next cycle: redirect_valid=1, new_priv=1, redirect_pc = stvec.BASE<<2, plus 4*trap_cause if MODE=1 and trap_is_irq.
- SRET, when sret_valid (and no trap):
  - SIE<=SPIE, SPIE<=1, SPP<=0.
  - Next cycle: redirect_valid=1, redirect_pc=sepc, new_priv={1'b0, SPP}.
- Priority within one cycle: trap > sret > CSR write.
  - A CSR write in the same cycle as a trap or sret is dropped entirely, including writes to unrelated registers.
  - csr_rdata still shows the pre-edge value.
- redirect_valid is high for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- irq_pending, registered: |(sip&sie) && (priv_lvl==0 || (priv_lvl==1 && SIE)). It is 0 when priv_lvl==3.
- Reset asserted mid-sequence clears any pending redirect; no pulse emerges after reset.
- With XLEN=32, satp is MODE[31] / ASID[30:22] / PPN[21:0]. With XLEN=64, satp is MODE[63:60] / ASID[59:44] / PPN[43:0].

Optional Feature:
CSR_SATP_EN
- Defined: satp is implemented. Writes whose MODE is not Bare (0) or Sv32 (1, XLEN=32) / Sv39 (8, XLEN=64) leave satp entirely unchanged. satp_out follows the register.
- Undefined: address 0x180 is still legal at S. It reads 0, writes are ignored, and satp_out ties to 0.

Test Plan:
- Reset, then read all nine CSRs at priv 3 -> all 0, stvec=VEC_EN_DEFAULT; redirect_valid=0.
- priv 0, CSRRW sscratch=0x55 -> csr_illegal=1, sscratch stays 0. Then priv 1, same op -> rdata 0, later read 0x55. Then CSRRC 0x05 -> value 0x50.
- CSRRW sstatus=all-ones -> reads 0x122. CSRRW stvec=0x8000_0003 -> reads 0x8000_0000 (MODE kept 0).
- SIE=1, stvec=0x1001 (vectored), trap_valid irq cause 5, pc=0x2004, priv 1 -> next cycle redirect_pc=0x1014, new_priv=1, sepc=0x2004, scause MSB=1 and low bits 5, SIE=0, SPIE=1, SPP=1.
- Follow-up sret_valid -> redirect_pc=0x2004, new_priv=1, SIE=1. Trap and sret plus CSR write in the same cycle -> trap wins, write dropped, single pulse.
- sie=0x200, ext_seip=1, priv 1, SIE=0 -> irq_pending=0. Set SIE -> irq_pending=1 one cycle later. priv 3 -> 0.

Source files
------------

// File: rtl/csr_supervisor_unit_if.sv
// CSR access bus between the execute stage (master) and the supervisor
// CSR file (slave).
//
// Handshake: the master holds csr_valid high for exactly the cycle in
// which the instruction executes, with csr_op/csr_addr/csr_wdata stable
// for that cycle. There is no ready: the slave always accepts. In that
// same cycle csr_rdata (old value) and csr_illegal are combinational
// replies, and any write takes effect at the closing clock edge.
interface csr_supervisor_unit_if #(
  parameter int XLEN = 64
);
  logic            csr_valid;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_valid, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_supervisor_unit.sv
// Supervisor-mode CSR file: CSRRW/RS/RC access with privilege and
// read-only checks, WARL masking, trap entry / SRET sequencing with a
// registered one-cycle PC redirect, and S-interrupt pending generation.
// Optional macro CSR_SATP_EN: when defined satp is a real register;
// otherwise 0x180 reads 0, ignores writes and satp_out is 0.
module csr_supervisor_unit #(
  parameter int XLEN           = 64,
  parameter int CAUSE_W        = 6,
  parameter int VEC_EN_DEFAULT = 0
) (
  input  logic               clk,
  input  logic               reset,
  csr_supervisor_unit_if.slave bus,
  input  logic [1:0]         priv_lvl,
  input  logic               trap_valid,
  input  logic               trap_is_irq,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_tval,
  input  logic               sret_valid,
  input  logic               ext_seip,
  input  logic               ext_stip,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [1:0]         new_priv,
  output logic               irq_pending,
  output logic [XLEN-1:0]    satp_out,
  output logic               redirect_state
);

  localparam logic [11:0] ADDR_SSTATUS  = 12'h100;
  localparam logic [11:0] ADDR_SIE      = 12'h104;
  localparam logic [11:0] ADDR_STVEC    = 12'h105;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_SEPC     = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
  localparam logic [11:0] ADDR_STVAL    = 12'h143;
  localparam logic [11:0] ADDR_SIP      = 12'h144;
  localparam logic [11:0] ADDR_SATP     = 12'h180;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] SIE_MASK = XLEN'(12'h222);

  typedef enum logic {RS_IDLE = 1'b0, RS_PULSE = 1'b1} rstate_t;

  // architectural state
  logic             sie_b, spie_b, spp_b;
  logic [XLEN-1:0]  sie_q;
  logic             ssip_q;
  logic [XLEN-1:2]  stvec_base;
  logic [1:0]       stvec_mode;
  logic [XLEN-1:0]  sscratch_q, sepc_q, scause_q, stval_q, satp_q;

  // access decode
  logic [XLEN-1:0]  sstatus_val, sie_val, sip_val, rd_val, wval, cause_val;
  logic             addr_hit, write_req, illegal, csr_we, irq_comb;
  logic [XLEN-1:0]  trap_target;
  rstate_t          state_q, state_d;

  // pack the sparse registers into their architectural views
  always_comb begin
    sstatus_val    = '0;
    sstatus_val[1] = sie_b;
    sstatus_val[5] = spie_b;
    sstatus_val[8] = spp_b;
    sie_val        = sie_q & SIE_MASK;
    sip_val        = '0;
    sip_val[1]     = ssip_q;
    sip_val[5]     = ext_stip;
    sip_val[9]     = ext_seip;
    cause_val              = '0;
    cause_val[CAUSE_W-1:0] = trap_cause;
    cause_val[XLEN-1]      = trap_is_irq;
  end

  // read mux, legality check and operation result
  always_comb begin
    addr_hit = 1'b1;
    rd_val   = '0;
    case (bus.csr_addr)
      ADDR_SSTATUS:  rd_val = sstatus_val;
      ADDR_SIE:      rd_val = sie_val;
      ADDR_STVEC:    rd_val = {stvec_base, stvec_mode};
      ADDR_SSCRATCH: rd_val = sscratch_q;
      ADDR_SEPC:     rd_val = sepc_q;
      ADDR_SCAUSE:   rd_val = scause_q;
      ADDR_STVAL:    rd_val = stval_q;
      ADDR_SIP:      rd_val = sip_val;
      ADDR_SATP:     rd_val = satp_q;
      default:       addr_hit = 1'b0;
    endcase
    // RS/RC with a zero operand are pure reads; RW always writes
    write_req = (bus.csr_op == OP_RW) ||
                (((bus.csr_op == OP_RS) || (bus.csr_op == OP_RC)) && (bus.csr_wdata != '0));
    illegal   = bus.csr_valid &&
                ((priv_lvl < bus.csr_addr[9:8]) || !addr_hit ||
                 ((bus.csr_addr[11:10] == 2'b11) && write_req));
    case (bus.csr_op)
      OP_RW:   wval = bus.csr_wdata;
      OP_RS:   wval = rd_val | bus.csr_wdata;
      OP_RC:   wval = rd_val & ~bus.csr_wdata;
      default: wval = rd_val;
    endcase
    // traps and SRET take the whole cycle; a concurrent write is dropped
    csr_we           = bus.csr_valid && !illegal && write_req && !trap_valid && !sret_valid;
    bus.csr_rdata    = illegal ? '0 : rd_val;
    bus.csr_illegal  = illegal;
  end

  // trap vector target and interrupt-pending condition
  always_comb begin
    trap_target = {stvec_base, 2'b00};
    if ((stvec_mode == 2'd1) && trap_is_irq)
      trap_target = trap_target + (XLEN'(trap_cause) << 2);
    irq_comb = (|(sip_val & sie_val)) &&
               ((priv_lvl == 2'd0) || ((priv_lvl == 2'd1) && sie_b));
  end

  // CSR state update: trap, then SRET, then software write
  always_ff @(posedge clk) begin
    if (reset) begin
      sie_b      <= 1'b0;
      spie_b     <= 1'b0;
      spp_b      <= 1'b0;
      sie_q      <= '0;
      ssip_q     <= 1'b0;
      stvec_base <= '0;
      stvec_mode <= 2'(VEC_EN_DEFAULT);
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
    end else if (trap_valid) begin
      sepc_q   <= trap_pc & ~XLEN'(1);
      stval_q  <= trap_tval;
      scause_q <= cause_val;
      spie_b   <= sie_b;
      sie_b    <= 1'b0;
      spp_b    <= priv_lvl[0];
    end else if (sret_valid) begin
      sie_b  <= spie_b;
      spie_b <= 1'b1;
      spp_b  <= 1'b0;
    end else if (csr_we) begin
      case (bus.csr_addr)
        ADDR_SSTATUS: begin
          sie_b  <= wval[1];
          spie_b <= wval[5];
          spp_b  <= wval[8];
        end
        ADDR_SIE:      sie_q      <= wval & SIE_MASK;
        ADDR_SIP:      ssip_q     <= wval[1];
        ADDR_STVEC: begin
          stvec_base <= wval[XLEN-1:2];
          if (wval[1:0] == 2'd0 || wval[1:0] == 2'd1)
            stvec_mode <= wval[1:0];
        end
        ADDR_SSCRATCH: sscratch_q <= wval;
        ADDR_SEPC:     sepc_q     <= wval & ~XLEN'(1);
        ADDR_SCAUSE:   scause_q   <= wval;
        ADDR_STVAL:    stval_q    <= wval;
        default:       ;
      endcase
    end
  end

`ifdef CSR_SATP_EN
  localparam int MODE_W = (XLEN == 32) ? 1 : 4;
  localparam logic [MODE_W-1:0] MODE_PAGED = MODE_W'((XLEN == 32) ? 1 : 8);
  logic [MODE_W-1:0] satp_new_mode;
  always_comb satp_new_mode = wval[XLEN-1 -: MODE_W];

  // satp accepts only Bare or the one supported paging mode
  always_ff @(posedge clk) begin
    if (reset)
      satp_q <= '0;
    else if (csr_we && (bus.csr_addr == ADDR_SATP) &&
             ((satp_new_mode == '0) || (satp_new_mode == MODE_PAGED)))
      satp_q <= wval;
  end
`else
  assign satp_q = '0;
`endif

  assign satp_out = satp_q;

  // redirect FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RS_IDLE;
    else       state_q <= state_d;
  end

  // redirect FSM: every trap or SRET produces one pulse the next cycle
  always_comb begin
    state_d = RS_IDLE;
    if (trap_valid || sret_valid) state_d = RS_PULSE;
  end

  // redirect FSM: outputs
  always_comb begin
    redirect_valid = (state_q == RS_PULSE);
    redirect_state = state_q;
  end

  // redirect target and privilege captured with the event
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc <= '0;
      new_priv    <= 2'd0;
    end else if (trap_valid) begin
      redirect_pc <= trap_target;
      new_priv    <= 2'd1;
    end else if (sret_valid) begin
      redirect_pc <= sepc_q;
      new_priv    <= {1'b0, spp_b};
    end
  end

  // registered interrupt-pending flag
  always_ff @(posedge clk) begin
    if (reset) irq_pending <= 1'b0;
    else       irq_pending <= irq_comb;
  end

endmodule

// File: tb/tb_csr_supervisor_unit.sv
// Directed bench for csr_supervisor_unit (XLEN=64, CAUSE_W=6,
// VEC_EN_DEFAULT=0) with hand-computed expected values.
module tb_csr_supervisor_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  priv_lvl;
  logic        trap_valid, trap_is_irq, sret_valid, ext_seip, ext_stip;
  logic [5:0]  trap_cause;
  logic [63:0] trap_pc, trap_tval;
  logic        redirect_valid, irq_pending, redirect_state;
  logic [63:0] redirect_pc, satp_out;
  logic [1:0]  new_priv;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] rd;
  logic        il;

  csr_supervisor_unit_if #(.XLEN(64)) bus ();

  csr_supervisor_unit #(.XLEN(64), .CAUSE_W(6), .VEC_EN_DEFAULT(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .priv_lvl       (priv_lvl),
    .trap_valid     (trap_valid),
    .trap_is_irq    (trap_is_irq),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .sret_valid     (sret_valid),
    .ext_seip       (ext_seip),
    .ext_stip       (ext_stip),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .new_priv       (new_priv),
    .irq_pending    (irq_pending),
    .satp_out       (satp_out),
    .redirect_state (redirect_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one CSR instruction: reply is sampled mid-cycle, write lands at the edge
  task automatic csr_access(input logic [1:0] p, input logic [1:0] op, input logic [11:0] a,
                            input logic [63:0] wd, output logic [63:0] r, output logic ill);
    priv_lvl      = p;
    bus.csr_valid = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = a;
    bus.csr_wdata = wd;
    #2;
    r   = bus.csr_rdata;
    ill = bus.csr_illegal;
    tick();
    bus.csr_valid = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_wdata = '0;
  endtask

  task automatic expect_read(input string tag, input logic [1:0] p, input logic [11:0] a,
                             input logic [63:0] exp);
    logic [63:0] r;
    logic        ill;
    csr_access(p, 2'b00, a, 64'h0, r, ill);
    check({tag, "_val"}, r, exp);
    check({tag, "_ill"}, {63'd0, ill}, 64'd0);
  endtask

  task automatic csr_rw(input logic [1:0] p, input logic [11:0] a, input logic [63:0] wd);
    logic [63:0] r;
    logic        ill;
    csr_access(p, 2'b01, a, wd, r, ill);
  endtask

  logic [11:0] addrs [9] = '{12'h100, 12'h104, 12'h105, 12'h140, 12'h141,
                             12'h142, 12'h143, 12'h144, 12'h180};

  initial begin
    reset = 1'b1; priv_lvl = 2'd3;
    trap_valid = 0; trap_is_irq = 0; sret_valid = 0; ext_seip = 0; ext_stip = 0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    bus.csr_valid = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_new_priv", {62'd0, new_priv}, 64'd0);
    check("rst_irq_pending", {63'd0, irq_pending}, 64'd0);
    check("rst_satp_out", satp_out, 64'd0);
    for (int i = 0; i < 9; i++)
      expect_read($sformatf("rst_csr_%h", addrs[i]), 2'd3, addrs[i], 64'd0);

    // privilege check, then RW/RC on sscratch
    csr_access(2'd0, 2'b01, 12'h140, 64'h55, rd, il);
    check("u_sscratch_ill", {63'd0, il}, 64'd1);
    check("u_sscratch_rdata", rd, 64'd0);
    expect_read("sscratch_kept", 2'd1, 12'h140, 64'd0);
    csr_access(2'd1, 2'b01, 12'h140, 64'h55, rd, il);
    check("s_sscratch_ill", {63'd0, il}, 64'd0);
    check("s_sscratch_old", rd, 64'd0);
    expect_read("sscratch_55", 2'd1, 12'h140, 64'h55);
    csr_access(2'd1, 2'b11, 12'h140, 64'h05, rd, il);
    check("rc_old", rd, 64'h55);
    expect_read("sscratch_50", 2'd1, 12'h140, 64'h50);

    // unimplemented and M-level addresses
    csr_access(2'd3, 2'b00, 12'h106, 64'h0, rd, il);
    check("unimpl_ill", {63'd0, il}, 64'd1);
    csr_access(2'd1, 2'b00, 12'h300, 64'h0, rd, il);
    check("mlevel_ill", {63'd0, il}, 64'd1);

    // WARL masks
    csr_rw(2'd1, 12'h100, '1);
    expect_read("sstatus_warl", 2'd1, 12'h100, 64'h122);
    csr_rw(2'd1, 12'h105, 64'h8000_0003);
    expect_read("stvec_warl", 2'd1, 12'h105, 64'h8000_0000);
    csr_rw(2'd1, 12'h141, 64'h1235);
    expect_read("sepc_warl", 2'd1, 12'h141, 64'h1234);
    csr_rw(2'd1, 12'h104, '1);
    expect_read("sie_warl", 2'd1, 12'h104, 64'h222);
    csr_rw(2'd1, 12'h144, '1);
    expect_read("sip_warl", 2'd1, 12'h144, 64'h2);

    // satp
    csr_rw(2'd1, 12'h180, 64'h8000_0000_0000_0001);
`ifdef CSR_SATP_EN
    expect_read("satp_sv39", 2'd1, 12'h180, 64'h8000_0000_0000_0001);
    check("satp_out_sv39", satp_out, 64'h8000_0000_0000_0001);
    csr_rw(2'd1, 12'h180, 64'h9000_0000_0000_0002);
    expect_read("satp_badmode", 2'd1, 12'h180, 64'h8000_0000_0000_0001);
`else
    expect_read("satp_off", 2'd1, 12'h180, 64'd0);
    check("satp_out_off", satp_out, 64'd0);
`endif

    // interrupt trap into a vectored stvec
    csr_rw(2'd1, 12'h100, 64'h2);
    csr_rw(2'd1, 12'h105, 64'h1001);
    priv_lvl = 2'd1;
    trap_valid = 1; trap_is_irq = 1; trap_cause = 6'd5;
    trap_pc = 64'h2004; trap_tval = 64'hdead;
    tick();
    trap_valid = 0; trap_is_irq = 0;
    check("trap_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("trap_redirect_pc", redirect_pc, 64'h1014);
    check("trap_new_priv", {62'd0, new_priv}, 64'd1);
    expect_read("trap_sepc", 2'd1, 12'h141, 64'h2004);
    check("trap_pulse_end", {63'd0, redirect_valid}, 64'd0);
    expect_read("trap_scause", 2'd1, 12'h142, 64'h8000_0000_0000_0005);
    expect_read("trap_stval", 2'd1, 12'h143, 64'hdead);
    expect_read("trap_sstatus", 2'd1, 12'h100, 64'h120);

    // SRET back
    sret_valid = 1;
    tick();
    sret_valid = 0;
    check("sret_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("sret_redirect_pc", redirect_pc, 64'h2004);
    check("sret_new_priv", {62'd0, new_priv}, 64'd1);
    expect_read("sret_sstatus", 2'd1, 12'h100, 64'h22);

    // trap + sret + CSR write in one cycle: trap wins, write dropped
    priv_lvl = 2'd1;
    bus.csr_valid = 1; bus.csr_op = 2'b01; bus.csr_addr = 12'h140; bus.csr_wdata = 64'hAAAA;
    trap_valid = 1; sret_valid = 1; trap_is_irq = 0; trap_cause = 6'd2;
    trap_pc = 64'h3001; trap_tval = 64'h0;
    #2;
    check("combo_rdata_pre", bus.csr_rdata, 64'h50);
    tick();
    bus.csr_valid = 0; bus.csr_op = 0; trap_valid = 0; sret_valid = 0;
    check("combo_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("combo_redirect_pc", redirect_pc, 64'h1000);
    check("combo_new_priv", {62'd0, new_priv}, 64'd1);
    tick();
    check("combo_single_pulse", {63'd0, redirect_valid}, 64'd0);
    expect_read("combo_sscratch", 2'd1, 12'h140, 64'h50);
    expect_read("combo_sepc", 2'd1, 12'h141, 64'h3000);
    expect_read("combo_sstatus", 2'd1, 12'h100, 64'h120);

    // interrupt pending
    csr_rw(2'd1, 12'h104, 64'h200);
    ext_seip = 1;
    tick(); tick();
    check("irq_sie_clear", {63'd0, irq_pending}, 64'd0);
    expect_read("sip_live", 2'd1, 12'h144, 64'h202);
    csr_access(2'd1, 2'b10, 12'h100, 64'h2, rd, il);
    tick();
    check("irq_sie_set", {63'd0, irq_pending}, 64'd1);
    priv_lvl = 2'd3;
    tick();
    check("irq_priv_m", {63'd0, irq_pending}, 64'd0);
    priv_lvl = 2'd0;
    tick();
    check("irq_priv_u", {63'd0, irq_pending}, 64'd1);
    ext_seip = 0;

    // reset during a trap: no pulse afterwards
    priv_lvl = 2'd1;
    trap_valid = 1; trap_is_irq = 0; trap_cause = 6'd1; trap_pc = 64'h4000;
    reset = 1;
    tick();
    trap_valid = 0;
    check("rst_mid_redirect", {63'd0, redirect_valid}, 64'd0);
    tick();
    reset = 0;
    tick();
    check("rst_mid_after", {63'd0, redirect_valid}, 64'd0);
    check("rst_mid_irq", {63'd0, irq_pending}, 64'd0);
    expect_read("rst_mid_stvec", 2'd1, 12'h105, 64'd0);
    expect_read("rst_mid_sscratch", 2'd1, 12'h140, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
